// File: rtl/ab_input_debouncer.sv
// ---------------------------------------------------------------------------
// ab_input_debouncer
//   Two-channel input conditioner for the 2-input AND stage. Each raw,
//   asynchronous, bouncy switch level is synchronised to clk and filtered.
//   The filtered level only changes after the synchronised input has held
//   its new value for DEB_CYCLES consecutive cycles. One-cycle rise/fall
//   pulses are produced on the edge where a filtered level changes.
//
// Parameters
//   DEB_CYCLES : cycles a new level must persist (1 .. 2**CNT_W-1)
//   CNT_W      : width of each channel's stability counter
//
// Ports
//   clk    : system clock, rising-edge active
//   rst_n  : asynchronous active-low reset
//   SW_A   : raw level, channel A
//   SW_B   : raw level, channel B
//   A, B   : debounced levels, feed the AND stage inputs
//   A_rise : one-cycle pulse when A goes 0->1
//   A_fall : one-cycle pulse when A goes 1->0
//   B_rise : one-cycle pulse when B goes 0->1
//   B_fall : one-cycle pulse when B goes 1->0
//
//   No combinational path exists from SW_* to any output.
// ---------------------------------------------------------------------------
module ab_input_debouncer #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SW_A,
  input  logic SW_B,
  output logic A,
  output logic B,
  output logic A_rise,
  output logic A_fall,
  output logic B_rise,
  output logic B_fall
);

  // The two channels are identical and share nothing but clock and reset.
  ab_debounce_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (SW_A),
    .level (A),
    .rise  (A_rise),
    .fall  (A_fall)
  );

  ab_debounce_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (SW_B),
    .level (B),
    .rise  (B_rise),
    .fall  (B_fall)
  );

endmodule

// ---------------------------------------------------------------------------
// ab_debounce_channel
//   One channel: 2-flop synchroniser followed by a STABLE/PENDING filter.
//
// Ports
//   clk, rst_n : clock and asynchronous active-low reset
//   sw         : raw asynchronous level
//   level      : registered debounced level
//   rise, fall : registered one-cycle change pulses
// ---------------------------------------------------------------------------
module ab_debounce_channel #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall
);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Count value on which a mismatch has persisted long enough to flip.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             next_level;
  logic             next_rise;
  logic             next_fall;
  logic             mismatch;

  // Two-flop synchroniser; only s2 is safe to use downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // Filter state and all outputs are registered together so the pulse
  // appears on exactly the edge where the level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      level <= next_level;
      rise  <= next_rise;
      fall  <= next_fall;
    end
  end

  // Next-state logic. Any return of s2 to the current level discards the
  // count, so a bounce during PENDING restarts the qualification window.
  // When DEB_CYCLES is 1 the very first mismatch already flips the level.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_level = level;
    next_rise  = 1'b0;
    next_fall  = 1'b0;
    mismatch   = (s2 != level);

    case (state)
      STABLE: begin
        next_cnt = '0;
        if (mismatch) begin
          if (LAST == '0) begin
            next_level = s2;
            next_rise  = s2;
            next_fall  = ~s2;
          end else begin
            next_cnt   = CNT_W'(1);
            next_state = PENDING;
          end
        end
      end
      PENDING: begin
        if (!mismatch) begin
          next_cnt   = '0;
          next_state = STABLE;
        end else if (cnt == LAST) begin
          next_level = s2;
          next_rise  = s2;
          next_fall  = ~s2;
          next_cnt   = '0;
          next_state = STABLE;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      default: begin
        next_cnt   = '0;
        next_state = STABLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ab_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_ab_input_debouncer
//   Directed bench for ab_input_debouncer with DEB_CYCLES=4. Inputs are
//   driven 1 time unit after a rising edge, so an input is "settled before"
//   the next edge; outputs are sampled at that same point. With this timing
//   a new level appears after exactly 6 edges. A model AND stage (x = A & B)
//   is attached to the debounced outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_ab_input_debouncer;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_a;
  logic sw_b;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;
  logic x;

  int checks = 0;
  int errors = 0;
  int a_rise_cnt = 0;
  int a_fall_cnt = 0;
  int b_rise_cnt = 0;
  int b_fall_cnt = 0;

  logic [1:0] hist[$];
  logic [1:0] sweep_pat[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
  logic [1:0] exp_ab;

  ab_input_debouncer #(
    .DEB_CYCLES (4),
    .CNT_W      (18)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .SW_A   (sw_a),
    .SW_B   (sw_b),
    .A      (a),
    .B      (b),
    .A_rise (a_rise),
    .A_fall (a_fall),
    .B_rise (b_rise),
    .B_fall (b_fall)
  );

  // Downstream AND stage fed by the debounced levels.
  assign x = a & b;

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic va, input logic vb);
    sw_a = va;
    sw_b = vb;
  endtask

  // Advance n rising edges, sampling 1 unit after each and tallying pulses.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      a_rise_cnt += int'(a_rise);
      a_fall_cnt += int'(a_fall);
      b_rise_cnt += int'(b_rise);
      b_fall_cnt += int'(b_fall);
    end
  endtask

  task automatic clear_counts();
    a_rise_cnt = 0;
    a_fall_cnt = 0;
    b_rise_cnt = 0;
    b_fall_cnt = 0;
  endtask

  initial begin
    // Reset with both switches high: outputs clear before any clock edge.
    rst_n = 1'b0;
    apply_stimulus(1'b1, 1'b1);
    #1;
    check_output("reset_a", a, 0);
    check_output("reset_b", b, 0);
    check_output("reset_pulses", {a_rise, a_fall, b_rise, b_fall}, 0);
    tick(3);
    check_output("reset_held_pulses", a_rise_cnt + a_fall_cnt + b_rise_cnt + b_fall_cnt, 0);
    rst_n = 1'b1;
    clear_counts();
    tick(5);
    check_output("post_reset_a_early", a, 0);
    check_output("post_reset_b_early", b, 0);
    check_output("post_reset_no_rise", a_rise_cnt + b_rise_cnt, 0);
    tick(1);
    check_output("post_reset_a", a, 1);
    check_output("post_reset_b", b, 1);
    check_output("post_reset_rises", {a_rise, b_rise}, 2'b11);
    tick(1);
    check_output("post_reset_rise_width", {a_rise, b_rise}, 2'b00);

    // Clean falling step on A; B must be untouched.
    clear_counts();
    apply_stimulus(1'b0, 1'b1);
    tick(5);
    check_output("fall_a_early", a, 1);
    tick(1);
    check_output("fall_a", a, 0);
    check_output("fall_a_pulse", {a_fall, a_rise}, 2'b10);
    check_output("fall_b_hold", b, 1);
    tick(1);
    check_output("fall_a_width", a_fall, 0);
    check_output("fall_counts", {a_fall_cnt[7:0], a_rise_cnt[7:0], b_fall_cnt[7:0], b_rise_cnt[7:0]}, 32'h01000000);

    // Clean rising step on A.
    clear_counts();
    apply_stimulus(1'b1, 1'b1);
    tick(5);
    check_output("rise_a_early", a, 0);
    tick(1);
    check_output("rise_a", a, 1);
    check_output("rise_a_pulse", {a_rise, a_fall}, 2'b10);
    tick(1);
    check_output("rise_a_width", a_rise, 0);
    check_output("rise_b_quiet", b_rise_cnt + b_fall_cnt, 0);

    // Return A to 0 before the glitch tests.
    apply_stimulus(1'b0, 1'b1);
    tick(8);
    check_output("settle_low", a, 0);

    // Three-cycle glitch is rejected.
    clear_counts();
    apply_stimulus(1'b1, 1'b1);
    tick(3);
    apply_stimulus(1'b0, 1'b1);
    tick(10);
    check_output("glitch3_a", a, 0);
    check_output("glitch3_pulses", a_rise_cnt + a_fall_cnt, 0);

    // Four synchronised cycles of high is enough to flip A.
    clear_counts();
    apply_stimulus(1'b1, 1'b1);
    tick(4);
    apply_stimulus(1'b0, 1'b1);
    tick(2);
    check_output("glitch4_a", a, 1);
    check_output("glitch4_rise", a_rise, 1);
    tick(8);
    check_output("glitch4_back_low", a, 0);
    check_output("glitch4_counts", {a_rise_cnt[7:0], a_fall_cnt[7:0]}, 16'h0101);

    // Bounce train 1,0,1,0 then hold 1: one rise, 6 edges after the last 0->1.
    clear_counts();
    apply_stimulus(1'b1, 1'b1);
    tick(1);
    apply_stimulus(1'b0, 1'b1);
    tick(1);
    apply_stimulus(1'b1, 1'b1);
    tick(1);
    apply_stimulus(1'b0, 1'b1);
    tick(1);
    apply_stimulus(1'b1, 1'b1);
    tick(5);
    check_output("bounce_a_early", a, 0);
    check_output("bounce_no_rise_yet", a_rise_cnt, 0);
    tick(1);
    check_output("bounce_a", a, 1);
    check_output("bounce_rise_count", a_rise_cnt, 1);
    tick(1);
    check_output("bounce_rise_width", a_rise, 0);

    // Reset in the middle of a pending count.
    apply_stimulus(1'b0, 1'b1);
    tick(8);
    check_output("premid_a", a, 0);
    apply_stimulus(1'b1, 1'b1);
    tick(3);
    rst_n = 1'b0;
    #1;
    check_output("midreset_a", a, 0);
    check_output("midreset_b", b, 0);
    check_output("midreset_pulses", {a_rise, a_fall, b_rise, b_fall}, 0);
    tick(2);
    rst_n = 1'b1;
    clear_counts();
    tick(5);
    check_output("midreset_a_early", a, 0);
    check_output("midreset_no_rise", a_rise_cnt, 0);
    tick(1);
    check_output("midreset_a_rise", {a, a_rise}, 2'b11);
    check_output("midreset_b_rise", {b, b_rise}, 2'b11);

    // AND-stage sweep: x follows (SW_A & SW_B) delayed by 6 edges.
    for (int i = 0; i < 5; i++) hist.push_back(2'b11);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 10; c++) begin
        apply_stimulus(sweep_pat[p][1], sweep_pat[p][0]);
        hist.push_back(sweep_pat[p]);
        tick(1);
        exp_ab = hist[hist.size() - 6];
        check_output("sweep_x", x, exp_ab[1] & exp_ab[0]);
        check_output("sweep_b", b, exp_ab[0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
